// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between the instruction
// fetch requester (I) and the data requester (D). D has priority, but after
// D_STREAK consecutive D grants taken while I was waiting, I is served once.
// A flush (i_cancel) drops a pending fetch or silences the ack of one in flight.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LAT      = 4,
  parameter int unsigned D_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W    = $clog2(LAT + 1);
  localparam int unsigned STREAK_W = $clog2(D_STREAK + 1);

  localparam logic [CNT_W-1:0]    CntLast   = CNT_W'(LAT);
  localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(D_STREAK);

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                cancel_q, cancel_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic i_eff;
  logic grant_d;
  logic grant_i;
  logic last_cycle;

  // A fetch flushed in the same cycle is not a candidate for the grant.
  assign i_eff      = i_req && !i_cancel;
  assign grant_d    = (state_q == StIdle) && d_req && !(i_eff && (streak_q == StreakMax));
  assign grant_i    = (state_q == StIdle) && i_eff && !grant_d;
  assign last_cycle = (cnt_q == CntLast);

  // Next-state, latency counter, starvation streak and latched transaction fields.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    cancel_d = cancel_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      StIdle: begin
        cnt_d    = '0;
        cancel_d = 1'b0;
        if (grant_d) begin
          state_d = StBusyD;
          wr_d    = d_wr;
          addr_d  = d_addr;
          wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d = StBusyI;
          wr_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
        end
      end
      StBusyI: begin
        // The memory op always runs to completion; only the ack is suppressed.
        if (i_cancel) begin
          cancel_d = 1'b1;
        end
        if (last_cycle) begin
          state_d  = StIdle;
          cnt_d    = '0;
          cancel_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBusyD: begin
        if (last_cycle) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Streak only measures D grants taken while I is actually waiting.
    if (!i_req || grant_i) begin
      streak_d = '0;
    end else if (grant_d && (streak_q != StreakMax)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      streak_q <= '0;
      cancel_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      streak_q <= streak_d;
      cancel_q <= cancel_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Strobes are gated by rst_n so a transaction being abandoned never acks.
  always_comb begin
    busy      = (state_q != StIdle);
    mem_en    = rst_n && busy && (cnt_q == '0);
    mem_wr    = wr_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    d_ack     = rst_n && (state_q == StBusyD) && last_cycle;
    i_ack     = rst_n && (state_q == StBusyI) && last_cycle && !cancel_q && !i_cancel;
    i_rdata   = i_ack ? mem_rdata : '0;
    d_rdata   = d_ack ? mem_rdata : '0;
  end

  ack_exclusive_a : assert property (@(posedge clk) disable iff (!rst_n) !(i_ack && d_ack));
  cnt_range_a     : assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CntLast);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random I/D traffic. A
// transaction-level reference model predicts launches and acks into queues;
// a monitor pops and compares them whenever the DUT strobes.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned LAT      = 4;
  localparam int unsigned D_STREAK = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_req = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic              i_cancel = 1'b0;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b0;
  logic              d_wr = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LAT     (LAT),
    .D_STREAK(D_STREAK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_cancel (i_cancel),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Memory behind the arbiter: data appears exactly LAT cycles after the launch
  // cycle, random junk otherwise. A write returns the written word.
  logic [DATA_W-1:0] tb_mem  [0:65535];
  logic [DATA_W-1:0] ref_mem [0:65535];
  int                launch_cyc = -100;
  logic [DATA_W-1:0] launch_data = '0;

  always @(negedge clk) begin
    if (mem_en) begin
      launch_cyc = cyc;
      if (mem_wr) begin
        tb_mem[mem_addr] = mem_wdata;
        launch_data      = mem_wdata;
      end else begin
        launch_data = tb_mem[mem_addr];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    mem_rdata = (cyc == launch_cyc + int'(LAT)) ? launch_data : 16'($urandom);
  end

  // Reference model: one decision per free cycle, service occupies LAT+1 cycles.
  typedef struct {
    int                cyc;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } launch_t;

  typedef struct {
    int                cyc;
    logic              side_i;
    logic [DATA_W-1:0] data;
  } ack_t;

  launch_t exp_launch_q[$];
  ack_t    exp_ack_q[$];

  int                free_at = 0;
  int                streak = 0;
  logic              act = 1'b0;
  logic              act_i = 1'b0;
  logic              act_cancel = 1'b0;
  int                act_start = 0;
  int                act_end = 0;
  logic [DATA_W-1:0] act_data = '0;
  logic              m_busy = 1'b0;
  logic              m_wr = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  int                nx_cyc = -1;
  logic              nx_wr = 1'b0;
  logic [ADDR_W-1:0] nx_addr = '0;
  logic [DATA_W-1:0] nx_wdata = '0;

  always @(negedge clk) begin : model
    logic    ieff;
    int      win;
    launch_t l;
    ack_t    a;
    if (cyc == nx_cyc) begin
      m_wr    = nx_wr;
      m_addr  = nx_addr;
      m_wdata = nx_wdata;
    end
    m_busy = act && (cyc >= act_start) && (cyc <= act_end);
    if (!rst_n) begin
      exp_launch_q.delete();
      exp_ack_q.delete();
      act      = 1'b0;
      streak   = 0;
      free_at  = cyc + 1;
      nx_cyc   = cyc + 1;
      nx_wr    = 1'b0;
      nx_addr  = '0;
      nx_wdata = '0;
    end else begin
      if (act && act_i && i_cancel && (cyc >= act_start) && (cyc <= act_end)) act_cancel = 1'b1;
      if (act && (cyc == act_end)) begin
        if (!act_i || !act_cancel) begin
          a.cyc    = cyc;
          a.side_i = act_i;
          a.data   = act_data;
          exp_ack_q.push_back(a);
        end
        act = 1'b0;
      end
      if (cyc >= free_at) begin
        ieff = i_req && !i_cancel;
        win  = 0;
        if (d_req && !(ieff && (streak == int'(D_STREAK)))) win = 1;
        else if (ieff) win = 2;
        if (win == 1) begin
          l.cyc = cyc + 1; l.wr = d_wr; l.addr = d_addr; l.wdata = d_wdata;
          act_data = d_wr ? d_wdata : ref_mem[d_addr];
          if (d_wr) ref_mem[d_addr] = d_wdata;
          act_i = 1'b0;
          if (i_req && (streak < int'(D_STREAK))) streak++;
        end else if (win == 2) begin
          l.cyc = cyc + 1; l.wr = 1'b0; l.addr = i_addr; l.wdata = '0;
          act_data = ref_mem[i_addr];
          act_i    = 1'b1;
          streak   = 0;
        end
        if (win != 0) begin
          exp_launch_q.push_back(l);
          act        = 1'b1;
          act_cancel = 1'b0;
          act_start  = cyc + 1;
          act_end    = cyc + 1 + int'(LAT);
          free_at    = cyc + 2 + int'(LAT);
          nx_cyc     = cyc + 1;
          nx_wr      = l.wr;
          nx_addr    = l.addr;
          nx_wdata   = l.wdata;
        end
      end
      if (!i_req) streak = 0;
    end
  end

  // Monitor: compares DUT strobes against the model's queues.
  int         n_iack = 0;
  logic       log_en = 1'b0;
  int         log_n = 0;
  logic [7:0] log_bits = '0;

  always @(negedge clk) begin : monitor
    launch_t el;
    ack_t    ea;
    #1;
    check("busy", busy, m_busy);
    check("mem_addr", mem_addr, m_addr);
    check("mem_wdata", mem_wdata, m_wdata);
    check("mem_wr", mem_wr, m_wr);
    check("ack_exclusive", i_ack & d_ack, 0);
    if (i_ack) n_iack++;
    if (mem_en) begin
      if (log_en && log_n < 8) begin
        log_bits[log_n] = mem_addr[15];
        log_n++;
      end
      if (exp_launch_q.size() == 0) begin
        check("launch_unexpected", mem_en, 0);
      end else begin
        el = exp_launch_q.pop_front();
        check("launch_cyc", cyc, el.cyc);
        check("launch_wr", mem_wr, el.wr);
        check("launch_addr", mem_addr, el.addr);
        check("launch_wdata", mem_wdata, el.wdata);
      end
    end else if (exp_launch_q.size() > 0 && exp_launch_q[0].cyc <= cyc) begin
      check("launch_missing", mem_en, 1);
      void'(exp_launch_q.pop_front());
    end
    if (i_ack || d_ack) begin
      if (exp_ack_q.size() == 0) begin
        check("ack_unexpected", {i_ack, d_ack}, 0);
      end else begin
        ea = exp_ack_q.pop_front();
        check("ack_cyc", cyc, ea.cyc);
        check("ack_side", {i_ack, d_ack}, ea.side_i ? 2'b10 : 2'b01);
        check("ack_rdata", ea.side_i ? i_rdata : d_rdata, ea.data);
      end
    end else begin
      check("rdata_idle", {i_rdata, d_rdata}, 0);
      if (exp_ack_q.size() > 0 && exp_ack_q[0].cyc <= cyc) begin
        ea = exp_ack_q.pop_front();
        check("ack_missing", {i_ack, d_ack}, ea.side_i ? 2'b10 : 2'b01);
      end
    end
  end

  task automatic wait_launch(output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_en && n < 20);
    at = cyc;
    if (!mem_en) check("launch_wait", mem_en, 1);
  endtask

  task automatic wait_d_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_ack && n < int'(LAT) + 20);
    if (!d_ack) check("d_ack_wait", d_ack, 1);
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic random_phase(input int n);
    logic da, ia;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      da = d_ack;
      ia = i_ack;
      @(posedge clk);
      #1;
      if (d_req && da) begin
        d_req = 1'b0;
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = 16'($urandom_range(0, 255));
        d_wdata = 16'($urandom);
      end
      i_cancel = 1'b0;
      if (i_req && ia) begin
        i_req = 1'b0;
      end else if ($urandom_range(0, 11) == 0) begin
        i_cancel = 1'b1;
        if ($urandom_range(0, 1) == 1) i_req = 1'b0;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req  = 1'b1;
        i_addr = 16'h8000 | 16'($urandom_range(0, 255));
      end
    end
  endtask

  initial begin : stimulus
    int li, ld, lt, iack0;
    for (int a = 0; a < 65536; a++) begin
      tb_mem[a]  = 16'(a * 40503) ^ 16'h5A5A;
      ref_mem[a] = 16'(a * 40503) ^ 16'h5A5A;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single load.
    @(posedge clk);
    #1 d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0010; d_wdata = 16'h0000;
    wait_d_ack();

    // Single store.
    @(posedge clk);
    #1 d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0030; d_wdata = 16'hBEEF;
    wait_d_ack();
    check("store_no_iack", n_iack, 0);

    // Reset in the middle of a load: no ack, everything cleared.
    @(posedge clk);
    #1 d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020; d_wdata = 16'h1234;
    wait_launch(lt);
    @(posedge clk);
    #1 rst_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("rst_d_ack", d_ack, 0);
    @(negedge clk);
    check("rst_ctrl", {busy, mem_en, i_ack, d_ack, mem_wr}, 0);
    check("rst_addr", {mem_addr, mem_wdata}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (int'(LAT) + 2) @(posedge clk);
    #1;

    // Continuous contention: D,D,D,I,D,D,D,I.
    log_en = 1'b1; log_n = 0; log_bits = '0;
    i_req = 1'b1; i_addr = 16'h8004;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
    begin
      int n = 0;
      while (log_n < 8 && n < 8 * (int'(LAT) + 2) + 10) begin
        @(posedge clk);
        n++;
      end
    end
    #1 i_req = 1'b0; d_req = 1'b0; log_en = 1'b0;
    check("grant_count", log_n, 8);
    check("grant_order", log_bits, 8'h88);
    repeat (int'(LAT) + 3) @(posedge clk);

    // Cancel of an in-flight fetch, with D waiting.
    #1 i_req = 1'b1; i_addr = 16'h8010;
    wait_launch(li);
    iack0 = n_iack;
    @(posedge clk);
    @(posedge clk);
    #1 i_cancel = 1'b1; i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0050;
    @(posedge clk);
    #1 i_cancel = 1'b0;
    wait_launch(ld);
    check("cancel_regrant", ld, li + int'(LAT) + 2);
    wait_d_ack();
    check("cancel_no_iack", n_iack, iack0);
    repeat (2) @(posedge clk);

    // Cancel together with a request in IDLE: nothing granted.
    #1 i_req = 1'b1; i_cancel = 1'b1; i_addr = 16'h8020;
    @(posedge clk);
    #1 i_req = 1'b0; i_cancel = 1'b0;
    @(negedge clk);
    check("cancel_idle_busy", busy, 0);
    check("cancel_idle_en", mem_en, 0);

    random_phase(2000);

    @(posedge clk);
    #1 i_req = 1'b0; d_req = 1'b0; i_cancel = 1'b0;
    repeat (int'(LAT) + 6) @(posedge clk);
    @(negedge clk);
    #2;
    check("launch_q_drained", exp_launch_q.size(), 0);
    check("ack_q_drained", exp_ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
